// File: rtl/hwpe_arb_pkg.sv
// Shared types and the round-robin pick used by the TCDM arbiter.
// id_t and tcdm_req_t widths follow the ARB_* constants below.
package hwpe_arb_pkg;

  localparam int unsigned ARB_N_REQ   = 3;
  localparam int unsigned ARB_MAX_OUT = 4;
  localparam int unsigned ARB_AW      = 32;
  localparam int unsigned ARB_DW      = 32;
  localparam int unsigned ID_W        = (ARB_N_REQ > 1) ? $clog2(ARB_N_REQ) : 1;

  typedef logic [ID_W-1:0] id_t;

  typedef struct packed {
    logic [ARB_AW-1:0]   add;
    logic                wen;
    logic [ARB_DW/8-1:0] be;
    logic [ARB_DW-1:0]   data;
  } tcdm_req_t;

  typedef struct packed {
    logic found;
    id_t  id;
  } rr_sel_t;

  // First requester at or after ptr, wrapping; ptr is assumed to be < ARB_N_REQ.
  function automatic rr_sel_t rr_select(input logic [ARB_N_REQ-1:0] req, input id_t ptr);
    rr_sel_t                 sel;
    logic [2*ARB_N_REQ-1:0]  rot;
    int unsigned             pos;
    sel = '0;
    rot = {req, req} >> ptr;
    for (int unsigned k = 0; k < ARB_N_REQ; k++) begin
      if (!sel.found && rot[k]) begin
        pos = 32'(ptr) + k;
        if (pos >= ARB_N_REQ) begin
          pos = pos - ARB_N_REQ;
        end
        sel.found = 1'b1;
        sel.id    = id_t'(pos);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/hwpe_arb_id_fifo.sv
// In-order FIFO of granted master IDs; one entry per outstanding transaction.
// Push while full and pop while empty are ignored.
module hwpe_arb_id_fifo
  import hwpe_arb_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic push_i,
  input  id_t  data_i,
  input  logic pop_i,
  output id_t  data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  id_t [Depth-1:0] r_mem;
  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [PtrW:0]   r_cnt;
  logic            w_push;
  logic            w_pop;

  assign full_o  = (r_cnt == (PtrW+1)'(Depth));
  assign empty_o = (r_cnt == '0);
  assign data_o  = r_mem[r_rptr];
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mem  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else if (clear_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= data_i;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (!w_push && w_pop) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/hwpe_tcdm_rr_arbiter.sv
// Round-robin arbiter sharing one TCDM port among N_REQ masters, in-order response routing.
// Optional per-master stall counters are built when HWPE_ARB_STALL_CNT_EN is defined.
module hwpe_tcdm_rr_arbiter
  import hwpe_arb_pkg::*;
#(
  parameter int unsigned N_REQ   = ARB_N_REQ,
  parameter int unsigned MAX_OUT = ARB_MAX_OUT,
  parameter int unsigned AW      = ARB_AW,
  parameter int unsigned DW      = ARB_DW
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  input  logic [N_REQ-1:0]             in_req_i,
  input  logic [N_REQ-1:0][AW-1:0]     in_add_i,
  input  logic [N_REQ-1:0]             in_wen_i,
  input  logic [N_REQ-1:0][DW/8-1:0]   in_be_i,
  input  logic [N_REQ-1:0][DW-1:0]     in_data_i,
  output logic [N_REQ-1:0]             in_gnt_o,
  output logic [DW-1:0]                in_r_data_o,
  output logic [N_REQ-1:0]             in_r_valid_o,
  output logic                         out_req_o,
  output logic [AW-1:0]                out_add_o,
  output logic                         out_wen_o,
  output logic [DW/8-1:0]              out_be_o,
  output logic [DW-1:0]                out_data_o,
  input  logic                         out_gnt_i,
  input  logic [DW-1:0]                out_r_data_i,
  input  logic                         out_r_valid_i,
  output logic                         busy_o,
  output logic                         err_o,
  output logic [N_REQ-1:0][31:0]       stall_cnt_o
);

  tcdm_req_t [N_REQ-1:0] w_reqs;
  tcdm_req_t             w_sel_req;
  rr_sel_t               w_sel;
  id_t                   r_ptr;
  id_t                   w_ptr_nxt;
  id_t                   w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_req;
  logic                  w_hs;
  logic                  w_pop;
  logic                  r_err;

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      w_reqs[i].add  = in_add_i[i];
      w_reqs[i].wen  = in_wen_i[i];
      w_reqs[i].be   = in_be_i[i];
      w_reqs[i].data = in_data_i[i];
    end
  end

  assign w_sel = rr_select(in_req_i, r_ptr);

  // rst_ni gates the outputs so nothing leaks out while reset is held.
  assign w_req = rst_ni & w_sel.found & ~w_full;
  assign w_hs  = w_req & out_gnt_i;
  assign w_pop = rst_ni & out_r_valid_i & ~w_empty;

  always_comb begin
    w_sel_req = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_req && (w_sel.id == id_t'(i))) begin
        w_sel_req = w_reqs[i];
      end
    end
  end

  assign out_req_o  = w_req;
  assign out_add_o  = w_sel_req.add;
  assign out_wen_o  = w_sel_req.wen;
  assign out_be_o   = w_sel_req.be;
  assign out_data_o = w_sel_req.data;

  always_comb begin
    in_gnt_o = '0;
    if (w_hs) begin
      in_gnt_o[w_sel.id] = 1'b1;
    end
  end

  always_comb begin
    in_r_valid_o = '0;
    if (w_pop) begin
      in_r_valid_o[w_head] = 1'b1;
    end
  end

  assign in_r_data_o = rst_ni ? out_r_data_i : '0;
  assign busy_o      = ~w_empty;
  assign err_o       = r_err;

  assign w_ptr_nxt = (w_sel.id == id_t'(N_REQ-1)) ? '0 : w_sel.id + id_t'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr <= '0;
    end else if (clear_i) begin
      r_ptr <= '0;
    end else if (w_hs) begin
      r_ptr <= w_ptr_nxt;
    end
  end

  // A response with nothing outstanding means the slave and this arbiter disagree.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else if (clear_i) begin
      r_err <= 1'b0;
    end else if (out_r_valid_i && w_empty) begin
      r_err <= 1'b1;
    end
  end

  hwpe_arb_id_fifo #(
    .Depth (MAX_OUT)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (w_hs),
    .data_i  (w_sel.id),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

`ifdef HWPE_ARB_STALL_CNT_EN
  logic [N_REQ-1:0][31:0] r_stall_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall_cnt <= '0;
    end else if (clear_i) begin
      r_stall_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (in_req_i[i] && !in_gnt_o[i] && (r_stall_cnt[i] != '1)) begin
          r_stall_cnt[i] <= r_stall_cnt[i] + 32'd1;
        end
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hwpe_tcdm_rr_arbiter.sv
// Directed bench for hwpe_tcdm_rr_arbiter: per-cycle compare against a queue-based model
// plus hand-computed expectations for each scenario.
module tb_hwpe_tcdm_rr_arbiter;

  localparam int N   = 3;
  localparam int MAX = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;

  logic                    clk;
  logic                    rst_n;
  logic                    clear;
  logic [N-1:0]            in_req;
  logic [N-1:0][AW-1:0]    in_add;
  logic [N-1:0]            in_wen;
  logic [N-1:0][DW/8-1:0]  in_be;
  logic [N-1:0][DW-1:0]    in_data;
  logic [N-1:0]            in_gnt;
  logic [DW-1:0]           in_r_data;
  logic [N-1:0]            in_r_valid;
  logic                    out_req;
  logic [AW-1:0]           out_add;
  logic                    out_wen;
  logic [DW/8-1:0]         out_be;
  logic [DW-1:0]           out_data;
  logic                    out_gnt;
  logic [DW-1:0]           out_r_data;
  logic                    out_r_valid;
  logic                    busy;
  logic                    err;
  logic [N-1:0][31:0]      stall_cnt;

  int total = 0;
  int bad   = 0;

  hwpe_tcdm_rr_arbiter u_dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .clear_i       (clear),
    .in_req_i      (in_req),
    .in_add_i      (in_add),
    .in_wen_i      (in_wen),
    .in_be_i       (in_be),
    .in_data_i     (in_data),
    .in_gnt_o      (in_gnt),
    .in_r_data_o   (in_r_data),
    .in_r_valid_o  (in_r_valid),
    .out_req_o     (out_req),
    .out_add_o     (out_add),
    .out_wen_o     (out_wen),
    .out_be_o      (out_be),
    .out_data_o    (out_data),
    .out_gnt_i     (out_gnt),
    .out_r_data_i  (out_r_data),
    .out_r_valid_i (out_r_valid),
    .busy_o        (busy),
    .err_o         (err),
    .stall_cnt_o   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_ptr;
  int          m_q[$];
  logic        m_err;
  logic [31:0] m_stall[N];
  int          m_sel;
  logic        m_found;
  logic        e_req;
  logic [N-1:0] e_gnt;
  logic [N-1:0] e_rv;
  logic [N-1:0] one;
  logic [31:0]  e_st;

  task automatic model_reset();
    m_ptr = 0;
    m_q.delete();
    m_err = 1'b0;
    for (int i = 0; i < N; i++) m_stall[i] = '0;
  endtask

  initial model_reset();

  always @(negedge clk) begin
    one = 3'b001;
    if (!rst_n) begin
      chk("rst_out_req", out_req, 0);
      chk("rst_gnt", in_gnt, 0);
      chk("rst_rvalid", in_r_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      chk("rst_out_add", out_add, 0);
      model_reset();
    end else begin
      m_found = 1'b0;
      m_sel   = 0;
      for (int k = 0; k < N; k++) begin
        if (!m_found && in_req[(m_ptr + k) % N]) begin
          m_found = 1'b1;
          m_sel   = (m_ptr + k) % N;
        end
      end
      e_req = m_found && (m_q.size() < MAX);
      e_gnt = (e_req && out_gnt) ? (one << m_sel) : '0;
      e_rv  = (out_r_valid && m_q.size() > 0) ? (one << m_q[0]) : '0;
      chk("m_out_req", out_req, e_req);
      chk("m_gnt", in_gnt, e_gnt);
      chk("m_rvalid", in_r_valid, e_rv);
      chk("m_busy", busy, m_q.size() != 0);
      chk("m_err", err, m_err);
      chk("m_add", out_add, e_req ? in_add[m_sel] : '0);
      chk("m_wen", out_wen, e_req ? in_wen[m_sel] : 1'b0);
      chk("m_be", out_be, e_req ? in_be[m_sel] : '0);
      chk("m_data", out_data, e_req ? in_data[m_sel] : '0);
      if (e_rv != '0) chk("m_rdata", in_r_data, out_r_data);
      for (int i = 0; i < N; i++) begin
`ifdef HWPE_ARB_STALL_CNT_EN
        e_st = m_stall[i];
`else
        e_st = '0;
`endif
        chk("m_stall", stall_cnt[i], e_st);
      end
      if (clear) begin
        model_reset();
      end else begin
        if (out_r_valid) begin
          if (m_q.size() == 0) m_err = 1'b1;
          else void'(m_q.pop_front());
        end
        if (e_gnt != '0) begin
          m_q.push_back(m_sel);
          m_ptr = (m_sel + 1) % N;
        end
        for (int i = 0; i < N; i++) begin
          if (in_req[i] && !e_gnt[i] && m_stall[i] != 32'hffff_ffff) m_stall[i] += 1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] r, input logic g, input logic v, input logic c);
    in_req      = r;
    out_gnt     = g;
    out_r_valid = v;
    clear       = c;
    out_r_data  = $urandom;
  endtask

  task automatic new_fields();
    for (int i = 0; i < N; i++) begin
      in_add[i]  = $urandom;
      in_wen[i]  = 1'($urandom_range(0, 1));
      in_be[i]   = 4'($urandom_range(1, 15));
      in_data[i] = $urandom;
    end
  endtask

  logic [N-1:0] lit_one;
  logic [31:0]  exp_stall;

  initial begin
    lit_one = 3'b001;
    rst_n = 1'b1;
    drive(3'b000, 1'b0, 1'b0, 1'b0);
    new_fields();
    #1 rst_n = 1'b0;
    tick();
    tick();
    #2;
    chk("rst_busy_lit", busy, 0);
    chk("rst_err_lit", err, 0);
    tick();
    rst_n = 1'b1;

    // All three request, slave grants every cycle, responses one cycle later.
    for (int k = 0; k < 7; k++) begin
      drive((k < 6) ? 3'b111 : 3'b000, 1'b1, k >= 1, 1'b0);
      #2;
      chk("t1_gnt", in_gnt, (k < 6) ? (lit_one << (k % 3)) : 3'b000);
      chk("t1_rvalid", in_r_valid, (k >= 1) ? (lit_one << ((k - 1) % 3)) : 3'b000);
      tick();
    end

    // Only master 2: granted every cycle, pointer wraps back to 0.
    new_fields();
    for (int k = 0; k < 5; k++) begin
      drive(3'b100, 1'b1, k >= 1, 1'b0);
      #2;
      chk("t2_gnt", in_gnt, 3'b100);
      tick();
    end
    drive(3'b111, 1'b1, 1'b1, 1'b0);
    #2;
    chk("t2_wrap_gnt", in_gnt, 3'b001);
    chk("t2_rvalid", in_r_valid, 3'b100);
    tick();
    drive(3'b000, 1'b0, 1'b1, 1'b0);
    #2;
    chk("t2_rvalid_last", in_r_valid, 3'b001);
    tick();

    // Responses withheld: four grants fill the FIFO, then the request drops.
    new_fields();
    for (int k = 0; k < 5; k++) begin
      drive(3'b001, 1'b1, 1'b0, 1'b0);
      #2;
      chk("t3_gnt", in_gnt, (k < 4) ? 3'b001 : 3'b000);
      chk("t3_req", out_req, k < 4);
      tick();
    end
    drive(3'b001, 1'b1, 1'b1, 1'b0);
    #2;
    chk("t3_nobypass", out_req, 0);
    chk("t3_pop", in_r_valid, 3'b001);
    tick();
    drive(3'b001, 1'b1, 1'b0, 1'b0);
    #2;
    chk("t3_regrant", in_gnt, 3'b001);
    tick();
    drive(3'b001, 1'b1, 1'b0, 1'b0);
    #2;
    chk("t3_full_again", out_req, 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(3'b000, 1'b0, 1'b1, 1'b0);
      tick();
    end

    // Slave refuses grant for 5 cycles with two requesters.
    drive(3'b000, 1'b0, 1'b0, 1'b1);
    tick();
    new_fields();
    for (int k = 0; k < 5; k++) begin
      drive(3'b011, 1'b0, 1'b0, 1'b0);
      #2;
      chk("t4_nognt", in_gnt, 3'b000);
      chk("t4_busy", busy, 0);
      tick();
    end
    drive(3'b011, 1'b1, 1'b0, 1'b0);
    #2;
`ifdef HWPE_ARB_STALL_CNT_EN
    exp_stall = 32'd5;
`else
    exp_stall = 32'd0;
`endif
    chk("t4_stall0", stall_cnt[0], exp_stall);
    chk("t4_stall1", stall_cnt[1], exp_stall);
    chk("t4_ptr_held", in_gnt, 3'b001);
    tick();
    drive(3'b000, 1'b0, 1'b1, 1'b0);
    tick();

    // Spurious response sets the sticky error; clear drops it.
    drive(3'b000, 1'b0, 1'b1, 1'b0);
    #2;
    chk("t5_no_rvalid", in_r_valid, 3'b000);
    tick();
    drive(3'b000, 1'b0, 1'b0, 1'b0);
    #2;
    chk("t5_err_set", err, 1);
    tick();
    drive(3'b000, 1'b0, 1'b0, 1'b1);
    #2;
    chk("t5_err_hold", err, 1);
    tick();
    drive(3'b000, 1'b0, 1'b0, 1'b0);
    #2;
    chk("t5_err_clr", err, 0);
    tick();

    // Async reset with three outstanding transactions.
    for (int k = 0; k < 3; k++) begin
      drive(3'b001, 1'b1, 1'b0, 1'b0);
      tick();
    end
    drive(3'b111, 1'b1, 1'b0, 1'b0);
    #2;
    chk("t6_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_gnt", in_gnt, 3'b000);
    chk("t6_req", out_req, 0);
    tick();
    rst_n = 1'b1;
    drive(3'b111, 1'b1, 1'b0, 1'b0);
    #2;
    chk("t6_after_gnt", in_gnt, 3'b001);
    tick();
    drive(3'b000, 1'b0, 1'b1, 1'b0);
    tick();
    drive(3'b000, 1'b0, 1'b0, 1'b0);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
